sa48_chunk_feeder: RTL and testbench
====================================

SA48_CHUNK_FEEDER -- requirements
Module: sa48_chunk_feeder

Interface
REQ-001 SHALL have parameter CHUNK_W, default 12, meaning chunk width in bits.
REQ-002 SHALL have parameter N_CHUNKS, default 4, meaning chunks per operand (operand width = CHUNK_W*N_CHUNKS = 48).
REQ-003 SHALL have parameter TIMEOUT, default 15, meaning the maximum number of cycles spent in WAIT before the block aborts.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  the single clock; all state updates on the rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 opA  input  48  operand A, sampled on accept.
REQ-008 opB  input  48  operand B, sampled on accept.
REQ-009 op_valid  input  1  upstream holds the operands valid.
REQ-010 op_ready  output  1  block can accept operands.
REQ-011 inBusA  output  12  chunk of A to the sequential adder.
REQ-012 inBusB  output  12  chunk of B to the sequential adder.
REQ-013 startChunks  output  1  one-cycle pulse marking chunk 0.
REQ-014 resultReady  input  1  adder result strobe.
REQ-015 outBus  input  48  adder result, valid while resultReady=1.
REQ-016 sum  output  48  captured result.
REQ-017 sum_valid  output  1  sum is valid; held until taken.
REQ-018 sum_ready  input  1  downstream takes sum.
REQ-019 timeout_err  output  1  one-cycle pulse on WAIT timeout.

Function
REQ-020 FSM states SHALL be IDLE, SEND, WAIT and HOLD.
REQ-021 op_ready SHALL be 1 only in IDLE; accept = op_valid & op_ready.
REQ-022 On accept, the block SHALL latch opA/opB into shift registers, clear chunk counter, and go to SEND.
REQ-023 SEND SHALL last exactly N_CHUNKS cycles; cycle k (k=0..3) SHALL drive inBusA/inBusB = bits [12k+11:12k] (LSB chunk first).
REQ-024 startChunks SHALL be 1 only in SEND cycle k=0, and 0 in every other cycle.
REQ-025 The first SEND cycle SHALL be the cycle after accept (accept-to-startChunks latency 1).
REQ-026 Outside SEND, inBusA/inBusB SHALL be driven to 0.
REQ-027 After SEND cycle k=N_CHUNKS-1, the FSM SHALL enter WAIT and clear the timeout counter.
REQ-028 In WAIT, when resultReady=1, the block SHALL capture outBus into sum and go to HOLD, with sum_valid=1 the next cycle.
REQ-029 In WAIT, a resultReady seen in the same cycle the counter reaches TIMEOUT SHALL count as capture, not timeout.
REQ-030 If the WAIT counter reaches TIMEOUT with no resultReady, the block SHALL pulse timeout_err for one cycle, leave sum unchanged, and return to IDLE.
REQ-031 resultReady SHALL be ignored in IDLE, SEND and HOLD.
REQ-032 In HOLD, sum and sum_valid SHALL stay stable until sum_ready=1; on that cycle the FSM SHALL return to IDLE, with op_ready=1 the next cycle.
REQ-033 A new operand SHALL NOT be accepted in the same cycle a result is taken; minimum throughput is one operation per N_CHUNKS+3 cycles.

Reset
REQ-034 While rst=1 at a clock edge, the FSM SHALL go to IDLE, overriding any in-flight operation in any state.
REQ-035 Reset values SHALL be: op_ready=1 in the first cycle after reset release; inBusA/inBusB=0, startChunks=0, sum=0, sum_valid=0, timeout_err=0; counters=0.

Structure
REQ-036 The FSM state enum, CHUNK_W, N_CHUNKS and the 48-bit operand width SHALL live in the shared SA48 package used by the adder.
REQ-037 The block SHALL be a single module without sub-modules; the top-level test wrapper SHALL instantiate it beside SA48 and connect the ports by name.

Verification
REQ-038 opA=0x000000000FFF, opB=0x000000000001 with the real SA48 -> chunks 0xFFF/0x001, 0x000/0x000 x3; sum=0x000000001000.
REQ-039 opA=opB=0xFFFFFFFFFFFF -> four chunks 0xFFF; sum=0xFFFFFFFFFFFE (48-bit wrap); startChunks high exactly one cycle.
REQ-040 Stub adder that never asserts resultReady -> timeout_err pulses TIMEOUT+1 cycles after the last chunk; FSM returns to IDLE; sum_valid stays 0.
REQ-041 sum_ready held 0 for 10 cycles, with op_valid=1 -> sum stable; op_ready stays 0; result taken on sum_ready=1; next operand accepted in the following cycle.
REQ-042 rst asserted in SEND cycle k=2 -> next cycle all outputs match reset values; a new operation then completes correctly.
REQ-043 Spurious resultReady in IDLE and SEND -> ignored; sum unchanged.

Source files
------------

// File: rtl/sa48_chunk_feeder_pkg.sv
// Shared SA48 definitions: operand geometry and the chunk-feeder FSM states.
package sa48_chunk_feeder_pkg;

  localparam int unsigned SA48_CHUNK_W   = 12;
  localparam int unsigned SA48_N_CHUNKS  = 4;
  localparam int unsigned SA48_OPERAND_W = SA48_CHUNK_W * SA48_N_CHUNKS;
  localparam int unsigned SA48_TIMEOUT   = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } feeder_state_e;

endpackage

// File: rtl/sa48_chunk_feeder.sv
// Feeds two wide operands LSB-chunk-first into the SA48 sequential adder and
// captures its result, with a bounded wait for the adder's result strobe.
module sa48_chunk_feeder
  import sa48_chunk_feeder_pkg::*;
#(
  parameter int unsigned CHUNK_W  = SA48_CHUNK_W,
  parameter int unsigned N_CHUNKS = SA48_N_CHUNKS,
  parameter int unsigned TIMEOUT  = SA48_TIMEOUT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CHUNK_W*N_CHUNKS-1:0] opA,
  input  logic [CHUNK_W*N_CHUNKS-1:0] opB,
  input  logic                        op_valid,
  output logic                        op_ready,
  output logic [CHUNK_W-1:0]          inBusA,
  output logic [CHUNK_W-1:0]          inBusB,
  output logic                        startChunks,
  input  logic                        resultReady,
  input  logic [CHUNK_W*N_CHUNKS-1:0] outBus,
  output logic [CHUNK_W*N_CHUNKS-1:0] sum,
  output logic                        sum_valid,
  input  logic                        sum_ready,
  output logic                        timeout_err
);

  localparam int unsigned OP_W  = CHUNK_W * N_CHUNKS;
  localparam int unsigned CNT_W = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam int unsigned TO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  feeder_state_e r_state;
  feeder_state_e w_state_nxt;

  logic [OP_W-1:0]    r_sh_a;
  logic [OP_W-1:0]    r_sh_b;
  logic [CNT_W-1:0]   r_chunk;
  logic [TO_W-1:0]    r_wait_cnt;
  logic               r_op_ready;
  logic [CHUNK_W-1:0] r_in_a;
  logic [CHUNK_W-1:0] r_in_b;
  logic               r_start;
  logic [OP_W-1:0]    r_sum;
  logic               r_sum_valid;
  logic               r_timeout;

  logic [OP_W-1:0]    w_sh_a_nxt;
  logic [OP_W-1:0]    w_sh_b_nxt;
  logic [OP_W-1:0]    w_sh_a_shift;
  logic [OP_W-1:0]    w_sh_b_shift;
  logic [CNT_W-1:0]   w_chunk_nxt;
  logic [TO_W-1:0]    w_wait_nxt;
  logic [TO_W-1:0]    w_wait_inc;
  logic               w_accept;
  logic               w_last_chunk;
  logic               w_op_ready_nxt;
  logic [CHUNK_W-1:0] w_in_a_nxt;
  logic [CHUNK_W-1:0] w_in_b_nxt;
  logic               w_start_nxt;
  logic [OP_W-1:0]    w_sum_nxt;
  logic               w_sum_valid_nxt;
  logic               w_timeout_nxt;

  assign w_accept     = op_valid & r_op_ready;
  assign w_last_chunk = (r_chunk == CNT_W'(N_CHUNKS - 1));
  assign w_wait_inc   = r_wait_cnt + TO_W'(1);
  assign w_sh_a_shift = r_sh_a >> CHUNK_W;
  assign w_sh_b_shift = r_sh_b >> CHUNK_W;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and next values of every registered output
  always_comb begin
    w_state_nxt     = r_state;
    w_sh_a_nxt      = r_sh_a;
    w_sh_b_nxt      = r_sh_b;
    w_chunk_nxt     = r_chunk;
    w_wait_nxt      = r_wait_cnt;
    w_in_a_nxt      = '0;
    w_in_b_nxt      = '0;
    w_start_nxt     = 1'b0;
    w_sum_nxt       = r_sum;
    w_sum_valid_nxt = r_sum_valid;
    w_timeout_nxt   = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_SEND;
          w_sh_a_nxt  = opA;
          w_sh_b_nxt  = opB;
          w_chunk_nxt = '0;
          w_in_a_nxt  = opA[CHUNK_W-1:0];
          w_in_b_nxt  = opB[CHUNK_W-1:0];
          w_start_nxt = 1'b1;
        end
      end
      ST_SEND: begin
        if (w_last_chunk) begin
          w_state_nxt = ST_WAIT;
          w_wait_nxt  = '0;
        end else begin
          w_chunk_nxt = r_chunk + CNT_W'(1);
          w_sh_a_nxt  = w_sh_a_shift;
          w_sh_b_nxt  = w_sh_b_shift;
          w_in_a_nxt  = w_sh_a_shift[CHUNK_W-1:0];
          w_in_b_nxt  = w_sh_b_shift[CHUNK_W-1:0];
        end
      end
      ST_WAIT: begin
        // A strobe on the final allowed cycle still wins over the timeout.
        if (resultReady) begin
          w_state_nxt     = ST_HOLD;
          w_sum_nxt       = outBus;
          w_sum_valid_nxt = 1'b1;
        end else if (w_wait_inc == TO_W'(TIMEOUT)) begin
          w_state_nxt   = ST_IDLE;
          w_wait_nxt    = '0;
          w_timeout_nxt = 1'b1;
        end else begin
          w_wait_nxt = w_wait_inc;
        end
      end
      ST_HOLD: begin
        if (sum_ready) begin
          w_state_nxt     = ST_IDLE;
          w_sum_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_op_ready_nxt = (w_state_nxt == ST_IDLE);
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh_a      <= '0;
      r_sh_b      <= '0;
      r_chunk     <= '0;
      r_wait_cnt  <= '0;
      r_op_ready  <= 1'b1;
      r_in_a      <= '0;
      r_in_b      <= '0;
      r_start     <= 1'b0;
      r_sum       <= '0;
      r_sum_valid <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_sh_a      <= w_sh_a_nxt;
      r_sh_b      <= w_sh_b_nxt;
      r_chunk     <= w_chunk_nxt;
      r_wait_cnt  <= w_wait_nxt;
      r_op_ready  <= w_op_ready_nxt;
      r_in_a      <= w_in_a_nxt;
      r_in_b      <= w_in_b_nxt;
      r_start     <= w_start_nxt;
      r_sum       <= w_sum_nxt;
      r_sum_valid <= w_sum_valid_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  assign op_ready    = r_op_ready;
  assign inBusA      = r_in_a;
  assign inBusB      = r_in_b;
  assign startChunks = r_start;
  assign sum         = r_sum;
  assign sum_valid   = r_sum_valid;
  assign timeout_err = r_timeout;

endmodule

// File: tb/tb_sa48_chunk_feeder.sv
// Bench for sa48_chunk_feeder: the bench plays upstream, adder and downstream,
// and predicts every output from the transaction schedule it chooses.
module tb_sa48_chunk_feeder;

  localparam int unsigned CW = 12;
  localparam int unsigned NC = 4;
  localparam int unsigned TO = 15;
  localparam int unsigned OW = CW * NC;

  logic          clk = 1'b0;
  logic          rst;
  logic [OW-1:0] opA, opB, outBus;
  logic          op_valid, resultReady, sum_ready;
  logic          op_ready, startChunks, sum_valid, timeout_err;
  logic [CW-1:0] inBusA, inBusB;
  logic [OW-1:0] sum;

  int unsigned   n_checks = 0;
  int unsigned   n_pass   = 0;
  logic [OW-1:0] m_sum;

  sa48_chunk_feeder #(.CHUNK_W(CW), .N_CHUNKS(NC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .opA(opA), .opB(opB), .op_valid(op_valid), .op_ready(op_ready),
    .inBusA(inBusA), .inBusB(inBusB), .startChunks(startChunks),
    .resultReady(resultReady), .outBus(outBus),
    .sum(sum), .sum_valid(sum_valid), .sum_ready(sum_ready),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic check_outs(input string ph, input bit e_ready, input logic [CW-1:0] e_a,
                            input logic [CW-1:0] e_b, input bit e_start, input bit e_sv,
                            input bit e_to);
    check({ph, ".op_ready"},    64'(op_ready),    64'(e_ready));
    check({ph, ".inBusA"},      64'(inBusA),      64'(e_a));
    check({ph, ".inBusB"},      64'(inBusB),      64'(e_b));
    check({ph, ".startChunks"}, 64'(startChunks), 64'(e_start));
    check({ph, ".sum_valid"},   64'(sum_valid),   64'(e_sv));
    check({ph, ".timeout_err"}, 64'(timeout_err), 64'(e_to));
    check({ph, ".sum"},         64'(sum),         64'(m_sum));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [OW-1:0] rand48();
    return OW'({$urandom(), $urandom()});
  endfunction

  function automatic logic [CW-1:0] chunk(input logic [OW-1:0] x, input int k);
    logic [OW-1:0] t;
    t = x >> (CW * k);
    return t[CW-1:0];
  endfunction

  // Junk on inputs the block must ignore in the current phase.
  task automatic noise();
    opA         = rand48();
    opB         = rand48();
    outBus      = rand48();
    resultReady = 1'($urandom_range(0, 1));
    sum_ready   = 1'b0;
  endtask

  // One operation; entered and left in an IDLE cycle. d=0 means the adder never answers.
  task automatic run_op(input logic [OW-1:0] a, input logic [OW-1:0] b, input int gap,
                        input int d, input int hold, input bit valid_in_hold);
    bit captured;
    for (int i = 0; i <= gap; i++) begin
      check_outs("idle", 1'b1, '0, '0, 1'b0, 1'b0, 1'b0);
      noise();
      op_valid = (i == gap);
      if (i == gap) begin
        opA = a;
        opB = b;
      end
      step();
    end
    for (int k = 0; k < int'(NC); k++) begin
      check_outs($sformatf("send%0d", k), 1'b0, chunk(a, k), chunk(b, k), k == 0, 1'b0, 1'b0);
      noise();
      op_valid = 1'($urandom_range(0, 1));
      step();
    end
    captured = 1'b0;
    for (int j = 1; j <= int'(TO) && !captured; j++) begin
      check_outs($sformatf("wait%0d", j), 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      noise();
      op_valid    = 1'($urandom_range(0, 1));
      resultReady = (j == d);
      if (j == d) begin
        outBus   = a + b;
        captured = 1'b1;
      end
      step();
    end
    if (!captured) begin
      check_outs("timeout", 1'b1, '0, '0, 1'b0, 1'b0, 1'b1);
      noise();
      op_valid = 1'b0;
      step();
    end else begin
      m_sum = a + b;
      for (int i = 0; i <= hold; i++) begin
        check_outs($sformatf("hold%0d", i), 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        noise();
        op_valid  = valid_in_hold ? 1'b1 : 1'($urandom_range(0, 1));
        sum_ready = (i == hold);
        step();
      end
      sum_ready = 1'b0;
    end
  endtask

  // Reset lands on the third SEND cycle; the block must come back clean.
  task automatic reset_mid_send(input logic [OW-1:0] a, input logic [OW-1:0] b);
    check_outs("rs_idle", 1'b1, '0, '0, 1'b0, 1'b0, 1'b0);
    noise();
    op_valid = 1'b1;
    opA = a;
    opB = b;
    step();
    for (int k = 0; k < 3; k++) begin
      check_outs($sformatf("rs_send%0d", k), 1'b0, chunk(a, k), chunk(b, k), k == 0, 1'b0, 1'b0);
      noise();
      op_valid = 1'b0;
      if (k == 2) rst = 1'b1;
      step();
    end
    m_sum = '0;
    check_outs("rs_after", 1'b1, '0, '0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    noise();
    op_valid = 1'b0;
    step();
  endtask

  initial begin
    rst         = 1'b1;
    opA         = '0;
    opB         = '0;
    outBus      = '0;
    op_valid    = 1'b0;
    resultReady = 1'b0;
    sum_ready   = 1'b0;
    m_sum       = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check_outs("reset", 1'b1, '0, '0, 1'b0, 1'b0, 1'b0);

    run_op(48'h000000000FFF, 48'h000000000001, 0, 3, 0, 1'b0);
    run_op(48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 2, int'(TO), 1, 1'b0);
    run_op(rand48(), rand48(), 1, 0, 0, 1'b0);
    run_op(rand48(), rand48(), 0, 1, 10, 1'b1);
    run_op(rand48(), rand48(), 0, 2, 0, 1'b0);
    reset_mid_send(rand48(), rand48());
    run_op(48'h123456789ABC, 48'h0FEDCBA98765, 0, 4, 2, 1'b0);

    for (int n = 0; n < 40; n++) begin
      run_op(rand48(), rand48(), int'($urandom_range(0, 3)), int'($urandom_range(0, TO)),
             int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
